// File: rtl/alu_sequencer.sv
// Instruction sequencer and 4-entry register file feeding a 4-bit combinational ALU.
// Each instruction takes three cycles: accept/read, ALU settle, writeback.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data,
    output logic       done,
    output logic [3:0] wb_data,
    output logic       zero,
    output logic       err
);

    localparam logic [3:0] OP_ALU_MAX = 4'b1011;
    localparam logic [3:0] OP_LOADI   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       retire;
    logic [3:0] regs [4];
    logic [1:0] rd_q;
    logic [3:0] imm_q;

    // Handshake: a transfer happens on a rising edge where instr_valid and
    // instr_ready are both high; upstream holds instr stable until then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        retire      = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_WB;
            end
            S_WB: begin
                retire     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // alu_op doubles as the latched opcode for the writeback decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            wb_data <= '0;
            done    <= 1'b0;
            zero    <= 1'b1;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                alu_a  <= regs[instr[3:2]];
                alu_b  <= regs[instr[1:0]];
                alu_op <= instr[9:6];
                rd_q   <= instr[5:4];
                imm_q  <= instr[3:0];
            end
            if (retire) begin
                done <= 1'b1;
                if (alu_op <= OP_ALU_MAX) begin
                    regs[rd_q] <= alu_result;
                    wb_data    <= alu_result;
                    zero       <= (alu_result == 4'd0);
                end else if (alu_op == OP_LOADI) begin
                    regs[rd_q] <= imm_q;
                    wb_data    <= imm_q;
                    zero       <= (imm_q == 4'd0);
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU and a retire scoreboard.
// Expected operands and retire values are queued at issue and checked by the monitor.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic [9:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_op;
    logic [3:0] alu_result;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic       done;
    logic [3:0] wb_data;
    logic       zero;
    logic       err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    logic acc_d = 1'b0;
    logic done_d = 1'b0;

    logic [11:0] opnd_q[$];
    logic [5:0]  exp_q[$];

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .done        (done),
        .wb_data     (wb_data),
        .zero        (zero),
        .err         (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream ALU model
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = ~alu_a;
            4'd1:    alu_result = alu_a & alu_b;
            4'd2:    alu_result = ~(alu_a & alu_b);
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = ~(alu_a | alu_b);
            4'd5:    alu_result = alu_a ^ alu_b;
            4'd6:    alu_result = ~(alu_a ^ alu_b);
            4'd7:    alu_result = alu_a << 1;
            4'd8:    alu_result = alu_a + alu_b;
            4'd9:    alu_result = alu_a - alu_b;
            4'd10:   alu_result = alu_a * alu_b;
            4'd11:   alu_result = (alu_b == 4'd0) ? 4'd0 : alu_a / alu_b;
            default: alu_result = 4'd0;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        acc_d  <= instr_valid && instr_ready && !rst;
        if (instr_valid && instr_ready && !rst) acc_cyc <= cyc;
    end

    always @(negedge clk) begin
        logic [11:0] o;
        logic [5:0]  e;
        if (acc_d) begin
            if (opnd_q.size() == 0) begin
                chk("unexpected_accept", 1, 0);
            end else begin
                o = opnd_q.pop_front();
                chk("alu_a", alu_a, o[11:8]);
                chk("alu_b", alu_b, o[7:4]);
                chk("alu_op", alu_op, o[3:0]);
            end
        end
        if (done) begin
            chk("done_twice", done_d, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_latency", cyc - acc_cyc, 3);
                chk("wb_data", wb_data, e[5:2]);
                chk("zero", zero, e[1]);
                chk("err", err, e[0]);
            end
        end
        done_d <= done;
    end

    // driver tasks
    task automatic issue(input logic [9:0] i, input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] ewb, input logic ez, input logic ee,
                         output logic with_done);
        bit got = 0;
        with_done = 1'b0;
        @(negedge clk);
        instr = i;
        instr_valid = 1'b1;
        opnd_q.push_back({ea, eb, i[9:6]});
        exp_q.push_back({ewb, ez, ee});
        for (int t = 0; t < 20 && !got; t++) begin
            if (instr_ready) begin
                got = 1;
                with_done = done;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 30 && exp_q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        chk("retire_timeout", exp_q.size(), 0);
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [3:0] v);
        dbg_addr = a;
        #1;
        chk($sformatf("reg%0d", a), dbg_data, v);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_zero", zero, 1);
        chk("rst_err", err, 0);
        chk("rst_wb", wb_data, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        for (int r = 0; r < 4; r++) chk_reg(r[1:0], 4'd0);
    endtask

    // stimulus
    initial begin
        logic wd;
        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        dbg_addr = '0;
        repeat (3) @(negedge clk);
        instr_valid = 1'b1;
        @(negedge clk);
        chk_reset_state();
        instr_valid = 1'b0;
        rst = 1'b0;

        // LOADI r1 = 0xA
        issue(10'b1100_01_10_10, 4'd0, 4'd0, 4'hA, 1'b0, 1'b0, wd);
        wait_idle();
        chk_reg(2'd1, 4'hA);

        // r1 = 5, r2 = 3, then ADD r3 = r1 + r2
        issue(10'b1100_01_01_01, 4'hA, 4'hA, 4'h5, 1'b0, 1'b0, wd);
        wait_idle();
        issue(10'b1100_10_00_11, 4'd0, 4'd0, 4'h3, 1'b0, 1'b0, wd);
        wait_idle();
        issue(10'b1000_11_01_10, 4'd5, 4'd3, 4'h8, 1'b0, 1'b0, wd);
        wait_idle();
        chk_reg(2'd3, 4'h8);

        // r2 = 7, then XOR r2, r2, r2 -> 0 with aliased operands
        issue(10'b1100_10_01_11, 4'd5, 4'd8, 4'h7, 1'b0, 1'b0, wd);
        wait_idle();
        issue(10'b0101_10_10_10, 4'd7, 4'd7, 4'h0, 1'b1, 1'b0, wd);
        wait_idle();
        chk_reg(2'd2, 4'h0);

        // illegal opcode, then SUB r0 = r1 - r3 = 5 - 8
        issue(10'b1110_00_00_00, 4'd0, 4'd0, 4'h0, 1'b1, 1'b1, wd);
        wait_idle();
        chk_reg(2'd0, 4'h0);
        issue(10'b1001_00_01_11, 4'd5, 4'd8, 4'hD, 1'b0, 1'b1, wd);
        wait_idle();
        chk_reg(2'd0, 4'hD);

        // handshake: junk held during EXEC/WB, dependent ADD back-to-back
        issue(10'b1000_01_00_01, 4'hD, 4'h5, 4'h2, 1'b0, 1'b1, wd);
        instr = 10'b0000_00_00_00;
        instr_valid = 1'b1;
        issue(10'b1000_10_01_01, 4'h2, 4'h2, 4'h4, 1'b0, 1'b1, wd);
        chk("accept_in_done_cycle", wd, 1);
        wait_idle();
        chk_reg(2'd0, 4'hD);
        chk_reg(2'd1, 4'h2);
        chk_reg(2'd2, 4'h4);

        // reset during EXEC drops the in-flight instruction
        issue(10'b1100_11_11_11, 4'h8, 4'h8, 4'hF, 1'b0, 1'b1, wd);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_state();
        repeat (3) @(negedge clk);
        chk("rst_hold_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);
        chk("post_rst_done", done, 0);
        issue(10'b1100_00_01_10, 4'd0, 4'd0, 4'h6, 1'b0, 1'b0, wd);
        wait_idle();
        chk_reg(2'd0, 4'h6);
        chk_reg(2'd3, 4'h0);

        repeat (4) @(negedge clk);
        chk("opnd_q_empty", opnd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
